signed_minmax_tracker: RTL and testbench

Sequential stage directly downstream of the team's signed comparator. It accepts a frame of LEN two's-complement samples over a valid/ready stream and uses two signed comparator instances (lt/eq/gt) to track the running minimum and maximum. It returns the minimum, the maximum and, optionally, their frame indices through an output valid/ready handshake. Typical use is frame statistics ahead of scaling/normalisation logic.

---
 rtl/signed_minmax_tracker_pkg.sv | 18 +
 rtl/signed_minmax_tracker_cmp.sv | 21 ++
 rtl/signed_minmax_tracker.sv | 113 +++++++++++
 tb/tb_signed_minmax_tracker.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/signed_minmax_tracker_pkg.sv
// Shared definitions for signed_minmax_tracker: FSM state encoding, default
// sizing and the index-width helper.
package signed_minmax_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_N   = 8;
  localparam int DEF_LEN = 16;

  function automatic int idxWidth(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/signed_minmax_tracker_cmp.sv
// Combinational full-width two's-complement comparator producing lt/eq/gt of a
// relative to b.
module signed_cmp
  import signed_minmax_tracker_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  always_comb begin
    lt = ($signed(a) <  $signed(b));
    eq = (a == b);
    gt = ($signed(a) >  $signed(b));
  end

endmodule

// File: rtl/signed_minmax_tracker.sv
// Tracks signed running min/max over a LEN-sample frame and presents the result
// on a valid/ready output. Index tracking is built only when MINMAX_IDX_EN is defined.
module signed_minmax_tracker
  import signed_minmax_tracker_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int LEN = DEF_LEN,
  localparam int IW = idxWidth(LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  min_out,
  output logic [N-1:0]  max_out,
  output logic [IW-1:0] min_idx,
  output logic [IW-1:0] max_idx
);

  state_t        state, stateNext;
  logic [IW-1:0] sampleCnt;
  logic [N-1:0]  minVal, maxVal;
  logic          accept, firstSample, lastSample;
  logic          minLt, minEq, minGt, maxLt, maxEq, maxGt;
  logic          minRepl, maxRepl;
  logic          unusedCmp;

  signed_cmp #(.N(N)) cmpMin (.a(in_data), .b(minVal), .lt(minLt), .eq(minEq), .gt(minGt));
  signed_cmp #(.N(N)) cmpMax (.a(in_data), .b(maxVal), .lt(maxLt), .eq(maxEq), .gt(maxGt));

  assign unusedCmp = minGt ^ maxLt;

  assign accept      = in_ready && in_valid;
  assign firstSample = (sampleCnt == '0);
  assign lastSample  = (sampleCnt == IW'(LEN - 1));
  // Ties never replace, so the earliest occurrence keeps its index.
  assign minRepl     = minLt && !minEq;
  assign maxRepl     = maxGt && !maxEq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = ACC;
      ACC:     if (accept && lastSample) stateNext = HOLD;
      HOLD:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ACC) || (state == HOLD);
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleCnt <= '0;
      minVal    <= '0;
      maxVal    <= '0;
    end else if (state == IDLE && start) begin
      sampleCnt <= '0;
    end else if (accept) begin
      if (!lastSample) sampleCnt <= sampleCnt + IW'(1);
      if (firstSample) begin
        minVal <= in_data;
        maxVal <= in_data;
      end else begin
        if (minRepl) minVal <= in_data;
        if (maxRepl) maxVal <= in_data;
      end
    end
  end

  assign min_out = minVal;
  assign max_out = maxVal;

`ifdef MINMAX_IDX_EN
  logic [IW-1:0] minIdx, maxIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minIdx <= '0;
      maxIdx <= '0;
    end else if (accept) begin
      if (firstSample) begin
        minIdx <= sampleCnt;
        maxIdx <= sampleCnt;
      end else begin
        if (minRepl) minIdx <= sampleCnt;
        if (maxRepl) maxIdx <= sampleCnt;
      end
    end
  end

  assign min_idx = minIdx;
  assign max_idx = maxIdx;
`else
  assign min_idx = '0;
  assign max_idx = '0;
`endif

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Scoreboard bench for signed_minmax_tracker (N=8, LEN=4); index expectations
// follow whether MINMAX_IDX_EN is defined.
module tb_signed_minmax_tracker;

  localparam int N   = 8;
  localparam int LEN = 4;
  localparam int IW  = 2;

  typedef struct {
    logic [N-1:0]  mn;
    logic [N-1:0]  mx;
    logic [IW-1:0] mnI;
    logic [IW-1:0] mxI;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          busy, in_ready, out_valid;
  logic [N-1:0]  min_out, max_out;
  logic [IW-1:0] min_idx, max_idx;

  exp_t sbQ[$];
  int   passCnt = 0;
  int   totalCnt = 0;
  int   acceptCnt = 0;

  signed_minmax_tracker #(.N(N), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .min_out(min_out), .max_out(max_out), .min_idx(min_idx), .max_idx(max_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [IW-1:0] expIdx(input int i);
`ifdef MINMAX_IDX_EN
    return IW'(i);
`else
    return (i == 0) ? '0 : '0;
`endif
  endfunction

  // Monitor: counts accepted samples and checks each delivered result.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) acceptCnt++;
    if (rst_n && out_valid && out_ready) begin
      if (sbQ.size() == 0) begin
        check("unexpectedResult", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        check("min_out", min_out, e.mn);
        check("max_out", max_out, e.mx);
        check("min_idx", min_idx, e.mnI);
        check("max_idx", max_idx, e.mxI);
      end
    end
  end

  task automatic pushExp(input logic [N-1:0] mn, input int mnI, input logic [N-1:0] mx, input int mxI);
    exp_t e;
    e.mn = mn; e.mx = mx; e.mnI = expIdx(mnI); e.mxI = expIdx(mxI);
    sbQ.push_back(e);
  endtask

  task automatic doStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("inReadyAfterStart", in_ready, 1'b1);
  endtask

  task automatic sendSamples(input logic [N-1:0] s0, s1, s2, s3, input bit toggle, input int n);
    logic [N-1:0] s[4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      if (i == LEN - 1) begin
        @(negedge clk);
        check("ovLowBeforeLast", out_valid, 1'b0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    if (n == LEN) begin
      check("ovAfterLast", out_valid, 1'b1);
      check("inReadyInHold", in_ready, 1'b0);
    end
  endtask

  task automatic drainResult();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovWait", out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ovFall", out_valid, 1'b0);
    check("idleAfterHs", busy, 1'b0);
  endtask

  initial begin
    int acc0;
    #1;
    check("resetOutputs", {busy, in_ready, out_valid, min_out, max_out, min_idx, max_idx}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Extremes: most negative and most positive values
    pushExp(8'h80, 3, 8'h7F, 2);
    doStart();
    sendSamples(8'h05, 8'hFD, 8'h7F, 8'h80, 1'b0, 4);
    drainResult();

    // All equal: no replacement on eq
    pushExp(8'h02, 0, 8'h02, 0);
    doStart();
    sendSamples(8'h02, 8'h02, 8'h02, 8'h02, 1'b0, 4);
    drainResult();

    // Gapped in_valid
    pushExp(8'hFF, 0, 8'h00, 2);
    acc0 = acceptCnt;
    doStart();
    sendSamples(8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1, 4);
    check("acceptCount", acceptCnt - acc0, 4);
    drainResult();

    // HOLD with back-pressure, stray start and in_valid
    pushExp(8'hF9, 1, 8'h09, 3);
    doStart();
    sendSamples(8'h03, 8'hF9, 8'hF9, 8'h09, 1'b0, 4);
    acc0 = acceptCnt;
    for (int c = 0; c < 5; c++) begin
      start    = (c == 2);
      in_valid = 1'b1;
      in_data  = 8'h80;
      @(negedge clk);
      check("holdMin", min_out, 8'hF9);
      check("holdMax", max_out, 8'h09);
      check("holdInReady", in_ready, 1'b0);
      check("holdOutValid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    in_valid = 1'b0;
    check("holdNoAccept", acceptCnt - acc0, 0);
    drainResult();

    // Mid-frame asynchronous reset
    doStart();
    sendSamples(8'h32, 8'hCE, 8'h00, 8'h00, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    check("resetMidFrame", {busy, in_ready, out_valid, min_out, max_out, min_idx, max_idx}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pushExp(8'h01, 0, 8'h04, 3);
    doStart();
    sendSamples(8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 4);
    drainResult();

    repeat (2) @(posedge clk);
    check("scoreboardDrained", sbQ.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
